// File: rtl/acc_ctrl_pkg.sv
// Shared types, register map and decode helpers for the acc_ctrl sequencing controller.
package acc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CAPTURE
    } state_t;

    localparam logic [11:0] CTRL_ADDR   = 12'h000;
    localparam logic [11:0] STATUS_ADDR = 12'h004;
    localparam logic [11:0] A_BASE      = 12'h100;
    localparam logic [11:0] B_BASE      = 12'h200;
    localparam logic [11:0] R_BASE      = 12'h300;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_IRQEN_BIT = 1;
    localparam int CTRL_CLR_BIT   = 2;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_ERR_BIT   = 2;
    localparam int STAT_IRQEN_BIT = 3;

    // Word-aligned match; the two byte-offset bits never take part in decode.
    function automatic logic isReg(input logic [11:0] addr, input logic [11:0] target);
        return addr[11:2] == target[11:2];
    endfunction

    function automatic logic inArray(input logic [11:0] addr, input logic [11:0] base, input int n);
        return (addr[11:8] == base[11:8]) && (int'(addr[7:2]) < n);
    endfunction

endpackage

// File: rtl/acc_ctrl_if.sv
// Word-addressed register slave bus between the core data port and acc_ctrl.
interface acc_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/acc_ctrl_regs.sv
// Operand (A/B) and result (R) register arrays with the combinational array read mux.
module acc_ctrl_regs
    import acc_ctrl_pkg::*;
#(
    parameter int DAT_SIZE = 8,
    parameter int MAT_SIZE = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_wrEn,
    input  logic [11:0]                              i_addr,
    input  logic [DAT_SIZE-1:0]                      i_wdata,
    input  logic                                     i_capture,
    input  logic [MAT_SIZE*MAT_SIZE*32-1:0]          i_accOut,
    output logic [MAT_SIZE*MAT_SIZE*DAT_SIZE-1:0]    o_accA,
    output logic [MAT_SIZE*MAT_SIZE*DAT_SIZE-1:0]    o_accB,
    output logic [31:0]                              o_rdata
);

    localparam int N    = MAT_SIZE * MAT_SIZE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    logic [DAT_SIZE-1:0] r_matA [N];
    logic [DAT_SIZE-1:0] r_matB [N];
    logic [31:0]         r_matR [N];

    logic [IDXW-1:0] w_idx;
    logic            w_hitA;
    logic            w_hitB;
    logic            w_hitR;

    assign w_idx  = i_addr[2 +: IDXW];
    assign w_hitA = inArray(i_addr, A_BASE, N);
    assign w_hitB = inArray(i_addr, B_BASE, N);
    assign w_hitR = inArray(i_addr, R_BASE, N);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                r_matA[k] <= '0;
                r_matB[k] <= '0;
                r_matR[k] <= '0;
            end
        end else begin
            if (i_wrEn && w_hitA) r_matA[w_idx] <= i_wdata;
            if (i_wrEn && w_hitB) r_matB[w_idx] <= i_wdata;
            if (i_capture) begin
                for (int k = 0; k < N; k++) r_matR[k] <= i_accOut[k*32 +: 32];
            end
        end
    end

    // Operand registers feed the accelerator directly; write locking keeps them frozen.
    for (genvar k = 0; k < N; k++) begin : g_pack
        assign o_accA[k*DAT_SIZE +: DAT_SIZE] = r_matA[k];
        assign o_accB[k*DAT_SIZE +: DAT_SIZE] = r_matB[k];
    end

    always_comb begin
        o_rdata = '0;
        if (w_hitA)      o_rdata = 32'(r_matA[w_idx]);
        else if (w_hitB) o_rdata = 32'(r_matB[w_idx]);
        else if (w_hitR) o_rdata = r_matR[w_idx];
    end

endmodule

// File: rtl/acc_ctrl.sv
// Sequencing controller: register slave, launch/wait/capture FSM and completion interrupt.
module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int DAT_SIZE    = 8,
    parameter int MAT_SIZE    = 2,
    parameter int ACC_LATENCY = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    acc_ctrl_if.slave                             bus,
    output logic [MAT_SIZE*MAT_SIZE*DAT_SIZE-1:0] acc_in_a_o,
    output logic [MAT_SIZE*MAT_SIZE*DAT_SIZE-1:0] acc_in_b_o,
    input  logic [MAT_SIZE*MAT_SIZE*32-1:0]       acc_out_i,
    output logic                                  acc_start_o,
    output logic                                  irq_o
);

    localparam int N    = MAT_SIZE * MAT_SIZE;
    localparam int CNTW = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(ACC_LATENCY - 1);

    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic            r_accStart;
    logic            r_done;
    logic            r_err;
    logic            r_irqEn;
    logic            r_rvalid;
    logic [31:0]     r_rdata;

    logic        w_busy;
    logic        w_wr;
    logic        w_rd;
    logic        w_ctrlWr;
    logic        w_start;
    logic        w_clr;
    logic        w_opHit;
    logic        w_capture;
    logic [31:0] w_status;
    logic [31:0] w_regsRdata;
    logic [31:0] w_rdMux;
    logic        w_unusedWdata;

    assign w_busy        = (r_state != IDLE);
    assign w_wr          = bus.req_i & bus.we_i;
    assign w_rd          = bus.req_i & ~bus.we_i;
    assign w_ctrlWr      = w_wr & isReg(bus.addr_i, CTRL_ADDR);
    assign w_start       = w_ctrlWr & bus.wdata_i[CTRL_START_BIT];
    assign w_clr         = w_ctrlWr & bus.wdata_i[CTRL_CLR_BIT];
    assign w_opHit       = inArray(bus.addr_i, A_BASE, N) | inArray(bus.addr_i, B_BASE, N);
    assign w_capture     = (r_state == CAPTURE);
    assign w_unusedWdata = ^bus.wdata_i;

    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = r_rdata;
    assign acc_start_o  = r_accStart;
    assign irq_o        = r_done & r_irqEn;

    acc_ctrl_regs #(
        .DAT_SIZE (DAT_SIZE),
        .MAT_SIZE (MAT_SIZE)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .i_wrEn    (w_wr & ~w_busy),
        .i_addr    (bus.addr_i),
        .i_wdata   (bus.wdata_i[DAT_SIZE-1:0]),
        .i_capture (w_capture),
        .i_accOut  (acc_out_i),
        .o_accA    (acc_in_a_o),
        .o_accB    (acc_in_b_o),
        .o_rdata   (w_regsRdata)
    );

    always_comb begin
        w_status                 = '0;
        w_status[STAT_BUSY_BIT]  = w_busy;
        w_status[STAT_DONE_BIT]  = r_done;
        w_status[STAT_ERR_BIT]   = r_err;
        w_status[STAT_IRQEN_BIT] = r_irqEn;
        w_rdMux = isReg(bus.addr_i, STATUS_ADDR) ? w_status : w_regsRdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= bus.req_i;
            r_rdata  <= w_rd ? w_rdMux : '0;
        end
    end

    // CLR is handled before START, so a combined write clears the flags and still launches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_accStart <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_irqEn    <= 1'b0;
        end else begin
            r_accStart <= 1'b0;
            if (w_ctrlWr && bus.wdata_i[CTRL_IRQEN_BIT]) r_irqEn <= 1'b1;
            if (w_clr) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_wr && w_busy && w_opHit) r_err <= 1'b1;
            if (w_start && w_busy)         r_err <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_accStart <= 1'b1;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) r_state <= CAPTURE;
                    else             r_cnt   <= r_cnt - CNTW'(1);
                end
                CAPTURE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
